// File: rtl/xor_stream_cipher_core.sv
// xor_stream_cipher_core: serial key/message loader, chunk-wise XOR encryptor
// (static or rolling key) and MSB-first serial ciphertext sender under one FSM.
`default_nettype none

module xor_stream_cipher_core #(
   parameter int MSG_SIZE = 64,
   parameter int KEY_SIZE = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic iData_in,
   input  logic iKey_flag,
   input  logic iMsg_flag,
   input  logic iMode,
   output logic oBusy,
   output logic oEnc_status,
   output logic oData_flag,
   output logic oData_out,
   output logic oDone,
   output logic oError
);

   localparam int NCHUNK    = MSG_SIZE / KEY_SIZE;
   localparam int KEY_CNT_W = $clog2(KEY_SIZE) + 1;
   localparam int MSG_CNT_W = $clog2(MSG_SIZE) + 1;
   localparam int CHUNK_W   = $clog2(NCHUNK + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ENCRYPT = 2'd1,
      S_SEND    = 2'd2,
      S_DONE    = 2'd3
   } state_e;

   state_e                 state_q, state_d;
   logic [KEY_SIZE-1:0]    key_q, key_d;
   logic [KEY_SIZE-1:0]    wkey_q, wkey_d;
   logic [MSG_SIZE-1:0]    msg_q, msg_d;
   logic [MSG_SIZE-1:0]    ct_q, ct_d;
   logic [KEY_CNT_W-1:0]   key_cnt_q, key_cnt_d;
   logic [MSG_CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
   logic [MSG_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [CHUNK_W-1:0]     chunk_cnt_q, chunk_cnt_d;
   logic                   key_prev_q, key_prev_d;
   logic                   msg_prev_q, msg_prev_d;
   logic                   mode_q, mode_d;
   logic                   busy_q, busy_d;
   logic                   enc_status_q, enc_status_d;
   logic                   data_flag_q, data_flag_d;
   logic                   data_out_q, data_out_d;
   logic                   done_q, done_d;
   logic                   error_q, error_d;

   always_comb begin
      state_d      = state_q;
      key_d        = key_q;
      wkey_d       = wkey_q;
      msg_d        = msg_q;
      ct_d         = ct_q;
      key_cnt_d    = key_cnt_q;
      msg_cnt_d    = msg_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      chunk_cnt_d  = chunk_cnt_q;
      key_prev_d   = key_prev_q;
      msg_prev_d   = msg_prev_q;
      mode_d       = mode_q;
      busy_d       = busy_q;
      enc_status_d = enc_status_q;
      data_flag_d  = data_flag_q;
      data_out_d   = data_out_q;
      done_d       = done_q;
      error_d      = error_q;

      if (ena) begin
         key_prev_d  = iKey_flag;
         msg_prev_d  = iMsg_flag;
         done_d      = 1'b0;
         error_d     = 1'b0;
         data_flag_d = 1'b0;
         data_out_d  = 1'b0;

         unique case (state_q)
            S_IDLE: begin
               // Key wins when both qualifiers are high; the message holds still.
               if (iKey_flag) begin
                  key_d = {key_q[KEY_SIZE-2:0], iData_in};
                  if (!key_prev_q)
                     key_cnt_d = KEY_CNT_W'(1);
                  else if (key_cnt_q != KEY_CNT_W'(KEY_SIZE))
                     key_cnt_d = key_cnt_q + KEY_CNT_W'(1);
               end else if (iMsg_flag) begin
                  msg_d = {msg_q[MSG_SIZE-2:0], iData_in};
                  if (!msg_prev_q)
                     msg_cnt_d = MSG_CNT_W'(1);
                  else if (msg_cnt_q != MSG_CNT_W'(MSG_SIZE))
                     msg_cnt_d = msg_cnt_q + MSG_CNT_W'(1);
                  if (msg_cnt_d == MSG_CNT_W'(MSG_SIZE)) begin
                     if (key_cnt_q == KEY_CNT_W'(KEY_SIZE)) begin
                        state_d     = S_ENCRYPT;
                        mode_d      = iMode;
                        wkey_d      = key_q;
                        chunk_cnt_d = '0;
                     end else begin
                        error_d   = 1'b1;
                        msg_cnt_d = '0;
                     end
                  end
               end
            end

            S_ENCRYPT: begin
               for (int i = 0; i < NCHUNK; i++) begin
                  if (chunk_cnt_q == CHUNK_W'(i))
                     ct_d[MSG_SIZE-1-i*KEY_SIZE -: KEY_SIZE] =
                        msg_q[MSG_SIZE-1-i*KEY_SIZE -: KEY_SIZE] ^ wkey_q;
               end
               if (mode_q)
                  wkey_d = {wkey_q[KEY_SIZE-2:0], wkey_q[KEY_SIZE-1]};
               if (chunk_cnt_q == CHUNK_W'(NCHUNK - 1)) begin
                  state_d     = S_SEND;
                  chunk_cnt_d = '0;
                  bit_cnt_d   = MSG_CNT_W'(1);
                  data_flag_d = 1'b1;
                  data_out_d  = ct_d[MSG_SIZE-1];
               end else begin
                  chunk_cnt_d = chunk_cnt_q + CHUNK_W'(1);
               end
            end

            S_SEND: begin
               // ct is shifted left as bits leave, so the next bit is always at MSB-1.
               if (bit_cnt_q == MSG_CNT_W'(MSG_SIZE)) begin
                  state_d   = S_DONE;
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
               end else begin
                  data_flag_d = 1'b1;
                  data_out_d  = ct_q[MSG_SIZE-2];
                  ct_d        = {ct_q[MSG_SIZE-2:0], 1'b0};
                  bit_cnt_d   = bit_cnt_q + MSG_CNT_W'(1);
               end
            end

            S_DONE: begin
               state_d   = S_IDLE;
               msg_cnt_d = '0;
            end

            default: state_d = S_IDLE;
         endcase

         busy_d       = (state_d != S_IDLE);
         enc_status_d = (state_d == S_ENCRYPT);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         key_q        <= '0;
         wkey_q       <= '0;
         msg_q        <= '0;
         ct_q         <= '0;
         key_cnt_q    <= '0;
         msg_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         chunk_cnt_q  <= '0;
         key_prev_q   <= 1'b0;
         msg_prev_q   <= 1'b0;
         mode_q       <= 1'b0;
         busy_q       <= 1'b0;
         enc_status_q <= 1'b0;
         data_flag_q  <= 1'b0;
         data_out_q   <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         key_q        <= key_d;
         wkey_q       <= wkey_d;
         msg_q        <= msg_d;
         ct_q         <= ct_d;
         key_cnt_q    <= key_cnt_d;
         msg_cnt_q    <= msg_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         chunk_cnt_q  <= chunk_cnt_d;
         key_prev_q   <= key_prev_d;
         msg_prev_q   <= msg_prev_d;
         mode_q       <= mode_d;
         busy_q       <= busy_d;
         enc_status_q <= enc_status_d;
         data_flag_q  <= data_flag_d;
         data_out_q   <= data_out_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign oBusy       = busy_q;
   assign oEnc_status = enc_status_q;
   assign oData_flag  = data_flag_q;
   assign oData_out   = data_out_q;
   assign oDone       = done_q;
   assign oError      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_stream_cipher_core.sv
// tb_xor_stream_cipher_core: table-driven vectors plus hand-written sequences
// for no-key error, both-flag priority, ena stall and mid-send reset.
`default_nettype none

module tb_xor_stream_cipher_core;
   localparam int MSG_SIZE = 64;
   localparam int KEY_SIZE = 8;
   localparam int NCHUNK   = MSG_SIZE / KEY_SIZE;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ena = 1'b0;
   logic iData_in = 1'b0;
   logic iKey_flag = 1'b0;
   logic iMsg_flag = 1'b0;
   logic iMode = 1'b0;
   logic oBusy, oEnc_status, oData_flag, oData_out, oDone, oError;

   int checks = 0;
   int failures = 0;
   int busy_in_load = 0;

   typedef struct {
      bit          load_key;
      logic [7:0]  key;
      logic [63:0] msg;
      bit          mode;
      int          stall_at;
      bit          toggle;
      logic [63:0] exp_ct;
      int          exp_done;
   } vec_t;

   xor_stream_cipher_core #(.MSG_SIZE(MSG_SIZE), .KEY_SIZE(KEY_SIZE)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .iData_in(iData_in),
      .iKey_flag(iKey_flag), .iMsg_flag(iMsg_flag), .iMode(iMode),
      .oBusy(oBusy), .oEnc_status(oEnc_status), .oData_flag(oData_flag),
      .oData_out(oData_out), .oDone(oDone), .oError(oError)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_flags();
      iKey_flag = 1'b0;
      iMsg_flag = 1'b0;
      iData_in  = 1'b0;
   endtask

   task automatic load_bits(input logic [63:0] val, input int n, input bit kf, input bit mf);
      for (int i = n - 1; i >= 0; i--) begin
         iData_in  = val[i];
         iKey_flag = kf;
         iMsg_flag = mf;
         if (oBusy) busy_in_load++;
         tick();
      end
   endtask

   // Entered in cycle t+1 (just after the edge that sampled the last message bit).
   task automatic observe(input string name, input logic [63:0] exp_ct, input int stall_at,
                          input bit toggle, input int exp_done);
      logic [63:0] ct;
      int bits, enc, first_k, done_k, bad0, bad_stall, errs, k;
      bit stalled;
      ct = '0; bits = 0; enc = 0; first_k = -1; done_k = -1;
      bad0 = 0; bad_stall = 0; errs = 0; k = 1; stalled = 1'b0;
      check({name, ":enc_at_t1"}, oEnc_status, 1);
      while (k < 300) begin
         if (oEnc_status) enc++;
         if (oError) errs++;
         if (oData_flag) begin
            if (first_k < 0) first_k = k;
            ct = {ct[62:0], oData_out};
            bits++;
         end else if (oData_out) begin
            bad0++;
         end
         if (oDone) begin
            done_k = k;
            break;
         end
         if (toggle && oData_flag) begin
            iKey_flag = 1'($urandom_range(0, 1));
            iMsg_flag = 1'($urandom_range(0, 1));
            iData_in  = 1'($urandom_range(0, 1));
         end
         if (stall_at >= 0 && !stalled && bits == stall_at) begin
            ena = 1'b0;
            for (int s = 0; s < 5; s++) begin
               tick();
               k++;
               if (!oData_flag) bad_stall++;
            end
            ena = 1'b1;
            stalled = 1'b1;
         end
         tick();
         k++;
      end
      clear_flags();
      check({name, ":enc_cycles"}, enc, NCHUNK);
      check({name, ":first_bit_cycle"}, first_k, NCHUNK + 1);
      check({name, ":bit_count"}, bits, MSG_SIZE);
      check({name, ":ciphertext"}, ct, exp_ct);
      check({name, ":done_cycle"}, done_k, exp_done);
      check({name, ":out_zero_unflagged"}, bad0, 0);
      check({name, ":no_error"}, errs, 0);
      if (stall_at >= 0) check({name, ":stall_hold"}, bad_stall, 0);
      tick();
   endtask

   initial begin
      vec_t vecs[5];
      int bits, seen;

      vecs[0] = '{load_key: 1'b1, key: 8'hAC, msg: 64'h0123456789ABCDEF, mode: 1'b0,
                  stall_at: -1, toggle: 1'b0, exp_ct: 64'hAD8FE9CB25076143, exp_done: 73};
      vecs[1] = '{load_key: 1'b1, key: 8'hAC, msg: 64'h0000000000000000, mode: 1'b1,
                  stall_at: -1, toggle: 1'b0, exp_ct: 64'hAC59B265CA952B56, exp_done: 73};
      vecs[2] = '{load_key: 1'b0, key: 8'h00, msg: 64'h0123456789ABCDEF, mode: 1'b0,
                  stall_at: -1, toggle: 1'b1, exp_ct: 64'hAD8FE9CB25076143, exp_done: 73};
      vecs[3] = '{load_key: 1'b1, key: 8'hAC, msg: 64'h0123456789ABCDEF, mode: 1'b0,
                  stall_at: 20, toggle: 1'b0, exp_ct: 64'hAD8FE9CB25076143, exp_done: 78};
      vecs[4] = '{load_key: 1'b1, key: 8'h01, msg: 64'h8000000000000001, mode: 1'b1,
                  stall_at: -1, toggle: 1'b0, exp_ct: 64'h8102040810204081, exp_done: 73};

      rst_n = 1'b0;
      ena = 1'b1;
      repeat (3) tick();
      check("reset_outputs", {oBusy, oEnc_status, oData_flag, oData_out, oDone, oError}, 0);
      rst_n = 1'b1;
      tick();

      for (int v = 0; v < 5; v++) begin
         if (vecs[v].load_key) load_bits({56'd0, vecs[v].key}, KEY_SIZE, 1'b1, 1'b0);
         iMode = vecs[v].mode;
         load_bits(vecs[v].msg, MSG_SIZE, 1'b0, 1'b1);
         clear_flags();
         observe($sformatf("vec%0d", v), vecs[v].exp_ct, vecs[v].stall_at,
                 vecs[v].toggle, vecs[v].exp_done);
      end

      // Both flags high: only the key shifts, message count continues from 0.
      iMode = 1'b0;
      load_bits(64'h00000000000000AC, KEY_SIZE, 1'b1, 1'b1);
      load_bits(64'h0123456789ABCDEF, MSG_SIZE, 1'b0, 1'b1);
      clear_flags();
      observe("both_flags", 64'hAD8FE9CB25076143, -1, 1'b0, 73);

      // Reset during send bit 30 (key AC retained from previous sequence).
      load_bits(64'h0123456789ABCDEF, MSG_SIZE, 1'b0, 1'b1);
      clear_flags();
      bits = 0;
      for (int k = 0; k < 100 && bits < 30; k++) begin
         if (oData_flag) bits++;
         if (bits < 30) tick();
      end
      check("reached_send_bit30", bits, 30);
      rst_n = 1'b0;
      #1;
      check("reset_mid_outputs", {oBusy, oEnc_status, oData_flag, oData_out, oDone, oError}, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 100; k++) begin
         if (oDone || oData_flag || oBusy) seen++;
         tick();
      end
      check("no_done_after_reset", seen, 0);

      // Key cleared by reset: message alone must raise oError at t+1.
      load_bits(64'h0123456789ABCDEF, MSG_SIZE, 1'b0, 1'b1);
      clear_flags();
      check("nokey_error_t1", oError, 1);
      check("nokey_not_busy", {oBusy, oEnc_status}, 0);
      tick();
      check("nokey_error_pulse", oError, 0);
      seen = 0;
      for (int k = 0; k < 80; k++) begin
         if (oData_flag || oBusy) seen++;
         tick();
      end
      check("nokey_no_stream", seen, 0);

      load_bits(64'h00000000000000FF, KEY_SIZE, 1'b1, 1'b0);
      iMode = 1'b0;
      load_bits(64'hFFFFFFFFFFFFFFFF, MSG_SIZE, 1'b0, 1'b1);
      clear_flags();
      observe("after_error_ff", 64'h0, -1, 1'b0, 73);

      check("busy_during_load", busy_in_load, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
